// File: rtl/volt_avg_pkg.sv
// Shared types and constants for the voltmeter averaging and display-mode block.
package volt_pkg;

  // Display modes, in the order the mode button cycles through them.
  typedef enum logic [1:0] {
    LIVE = 2'd0,
    HOLD = 2'd1,
    MAX  = 2'd2,
    MIN  = 2'd3
  } mode_t;

  // 13107 counts per volt, scaled by 1000 to give millivolts.
  localparam int MV_SCALE_NUM   = 32'd1000;
  localparam int MV_SCALE_DEN   = 32'd13107;
  localparam int MV_FULL_SCALE  = 32'd5000;

  localparam int DEF_DEPTH      = 32'd8;
  localparam int DEF_LOG2_DEPTH = 32'd3;

  // Mode that follows m when the mode button is pressed.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      LIVE:    r = HOLD;
      HOLD:    r = MAX;
      MAX:     r = MIN;
      MIN:     r = LIVE;
      default: r = LIVE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/volt_avg_rise_det.sv
// One-register rising-edge detector for an already synchronised level.
module rise_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev_r;

  // Remember the level seen at the previous clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level;
    end
  end

  // High for the single cycle in which the level has just gone high.
  assign pulse = level & ~prev_r;

endmodule

// File: rtl/volt_avg.sv
// Boxcar average of ADC codes, scaled to millivolts, with live/hold/max/min
// display modes feeding the seven-segment driver.
module volt_avg
  import volt_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int SCALE_NUM  = MV_SCALE_NUM,
  parameter int SCALE_DEN  = MV_SCALE_DEN
) (
  input  logic        clk_16hz,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic        mode_btn,
  input  logic        clr_btn,
  output logic [15:0] num,
  output logic        strobe,
  output logic [1:0]  mode,
  output logic        primed
);

  localparam int SUM_W  = 16 + LOG2_DEPTH;
  localparam int PROD_W = 26;
  localparam int CNT_W  = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [15:0]           samp_buf_r [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_r;
  logic [SUM_W-1:0]      sum_r;
  logic [15:0]           mv_r;
  logic [15:0]           avg_s;
  logic [PROD_W-1:0]     prod_s;
  logic [15:0]           mv_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  primed_r;
  logic                  mode_rise_s;
  logic                  clr_rise_s;
  mode_t                 mode_r, mode_nxt_s;
  logic [15:0]           peak_r, peak_nxt_s;
  logic [15:0]           num_r, num_nxt_s;
  logic                  strobe_r, strobe_nxt_s;

  rise_det u_mode_rise (
    .clk   (clk_16hz),
    .reset (reset),
    .level (mode_btn),
    .pulse (mode_rise_s)
  );

  rise_det u_clr_rise (
    .clk   (clk_16hz),
    .reset (reset),
    .level (clr_btn),
    .pulse (clr_rise_s)
  );

  // Circular sample buffer with a running sum; unwritten slots read as zero.
  always_ff @(posedge clk_16hz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        samp_buf_r[i] <= 16'd0;
      end
      wr_ptr_r <= {LOG2_DEPTH{1'b0}};
      sum_r    <= {SUM_W{1'b0}};
    end else begin
      samp_buf_r[wr_ptr_r] <= sample;
      sum_r    <= sum_r + SUM_W'(sample) - SUM_W'(samp_buf_r[wr_ptr_r]);
      wr_ptr_r <= wr_ptr_r + LOG2_DEPTH'(1'b1);
    end
  end

  // Average is the top 16 bits of the sum; scale to millivolts with truncation.
  assign avg_s    = sum_r[SUM_W-1 -: 16];
  assign prod_s   = PROD_W'(avg_s) * PROD_W'(SCALE_NUM);
  assign mv_nxt_s = 16'(prod_s / PROD_W'(SCALE_DEN));

  // Millivolt pipeline register.
  always_ff @(posedge clk_16hz or negedge reset) begin
    if (!reset) begin
      mv_r <= 16'd0;
    end else begin
      mv_r <= mv_nxt_s;
    end
  end

  // Saturating sample counter; primed rises with the write that fills the window.
  always_ff @(posedge clk_16hz or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      primed_r <= 1'b0;
    end else begin
      if (cnt_r != CNT_FULL) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      primed_r <= primed_r | (cnt_r == CNT_LAST);
    end
  end

  // Mode sequencing, peak tracking and the value presented to the display.
  always_comb begin
    mode_nxt_s   = mode_r;
    peak_nxt_s   = peak_r;
    num_nxt_s    = num_r;
    strobe_nxt_s = 1'b0;
    if (mode_rise_s) begin
      // A mode press wins over a simultaneous clear; entry already re-arms peak.
      mode_nxt_s = next_mode(mode_r);
      case (mode_nxt_s)
        LIVE: begin
          num_nxt_s    = mv_r;
          strobe_nxt_s = 1'b1;
        end
        HOLD: begin
          strobe_nxt_s = 1'b0;
        end
        MAX, MIN: begin
          peak_nxt_s   = mv_r;
          num_nxt_s    = mv_r;
          strobe_nxt_s = 1'b1;
        end
        default: begin
          strobe_nxt_s = 1'b0;
        end
      endcase
    end else begin
      case (mode_r)
        LIVE: begin
          num_nxt_s    = mv_r;
          strobe_nxt_s = 1'b1;
        end
        HOLD: begin
          strobe_nxt_s = 1'b0;
        end
        MAX: begin
          if (clr_rise_s || (mv_r > peak_r)) begin
            peak_nxt_s = mv_r;
            num_nxt_s  = mv_r;
          end else begin
            num_nxt_s  = peak_r;
          end
          strobe_nxt_s = 1'b1;
        end
        MIN: begin
          if (clr_rise_s || (mv_r < peak_r)) begin
            peak_nxt_s = mv_r;
            num_nxt_s  = mv_r;
          end else begin
            num_nxt_s  = peak_r;
          end
          strobe_nxt_s = 1'b1;
        end
        default: begin
          strobe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Registered mode, peak and display outputs.
  always_ff @(posedge clk_16hz or negedge reset) begin
    if (!reset) begin
      mode_r   <= LIVE;
      peak_r   <= 16'd0;
      num_r    <= 16'd0;
      strobe_r <= 1'b0;
    end else begin
      mode_r   <= mode_nxt_s;
      peak_r   <= peak_nxt_s;
      num_r    <= num_nxt_s;
      strobe_r <= strobe_nxt_s;
    end
  end

  assign num    = num_r;
  assign strobe = strobe_r;
  assign mode   = mode_r;
  assign primed = primed_r;

endmodule

// File: tb/tb_volt_avg.sv
// Directed bench for volt_avg with a window/queue reference model.
module tb_volt_avg;

  logic        clk_16hz = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] sample   = 16'd0;
  logic        mode_btn = 1'b0;
  logic        clr_btn  = 1'b0;
  logic [15:0] num;
  logic        strobe;
  logic [1:0]  mode;
  logic        primed;

  volt_avg dut (
    .clk_16hz (clk_16hz),
    .reset    (reset),
    .sample   (sample),
    .mode_btn (mode_btn),
    .clr_btn  (clr_btn),
    .num      (num),
    .strobe   (strobe),
    .mode     (mode),
    .primed   (primed)
  );

  always #5 clk_16hz = ~clk_16hz;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Reference model state
  int hist[$];
  int m_mv, m_num, m_strobe, m_mode, m_primed, m_peak, m_cnt;
  bit m_pm, m_pc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scale(input int window_sum);
    return ((window_sum / 8) * 1000) / 13107;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mv = 0; m_num = 0; m_strobe = 0; m_mode = 0; m_primed = 0;
    m_peak = 0; m_cnt = 0; m_pm = 1'b0; m_pc = 1'b0;
  endtask

  task automatic model_step(input int s, input bit mb, input bit cb);
    int wsum;
    int old_mv;
    bit mr;
    bit cr;
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      if (hist.size() - 1 - i >= 0) wsum += hist[hist.size() - 1 - i];
    end
    old_mv = m_mv;
    m_mv = scale(wsum);
    hist.push_back(s);
    m_cnt++;
    m_primed = (m_cnt >= 8) ? 1 : 0;
    mr = mb && !m_pm;
    cr = cb && !m_pc;
    m_pm = mb;
    m_pc = cb;
    if (mr) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 1) begin
        m_strobe = 0;
      end else begin
        m_num = old_mv;
        m_strobe = 1;
        if (m_mode >= 2) m_peak = old_mv;
      end
    end else if (m_mode == 0) begin
      m_num = old_mv;
      m_strobe = 1;
    end else if (m_mode == 1) begin
      m_strobe = 0;
    end else begin
      if (cr) m_peak = old_mv;
      else if (m_mode == 2) m_peak = (old_mv > m_peak) ? old_mv : m_peak;
      else m_peak = (old_mv < m_peak) ? old_mv : m_peak;
      m_num = m_peak;
      m_strobe = 1;
    end
  endtask

  // Every cycle: DUT outputs against the model, sampled on the falling edge.
  always @(negedge clk_16hz) begin
    if (check_en) begin
      chk("model_num", num, m_num);
      chk("model_strobe", strobe, m_strobe);
      chk("model_mode", mode, m_mode);
      chk("model_primed", primed, m_primed);
    end
  end

  task automatic tick(input int s, input bit mb, input bit cb);
    sample   = 16'(s);
    mode_btn = mb;
    clr_btn  = cb;
    @(posedge clk_16hz);
    model_step(s, mb, cb);
    @(negedge clk_16hz);
  endtask

  task automatic do_reset();
    #2;
    reset    = 1'b0;
    mode_btn = 1'b0;
    clr_btn  = 1'b0;
    model_reset();
    #1;
    chk("rst_num", num, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_mode", mode, 0);
    chk("rst_primed", primed, 0);
    @(posedge clk_16hz);
    @(negedge clk_16hz);
    reset = 1'b1;
  endtask

  int exp2 [12] = '{0, 0, 624, 1249, 1874, 2499, 3124, 3749, 4374, 5000, 5000, 5000};

  initial begin
    // Test 1: constant 1 V
    do_reset();
    check_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(13107, 1'b0, 1'b0);
      if (k == 7)  chk("t1_primed_e7", primed, 0);
      if (k == 8)  chk("t1_primed_e8", primed, 1);
      if (k >= 10) chk("t1_num_1000", num, 1000);
      if (k >= 3)  chk("t1_strobe", strobe, 1);
    end

    // Test 2: full-scale ramp
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(65535, 1'b0, 1'b0);
      chk("t2_num_seq", num, exp2[k]);
    end

    // Test 3: hold, then min
    do_reset();
    for (int k = 0; k < 10; k++) tick(13107, 1'b0, 1'b0);
    chk("t3_settled", num, 1000);
    tick(13107, 1'b1, 1'b0);
    tick(13107, 1'b1, 1'b0);
    chk("t3_hold_no_repeat", mode, 1);
    for (int k = 0; k < 10; k++) tick(26214, 1'b0, 1'b0);
    chk("t3_hold_num", num, 1000);
    chk("t3_hold_strobe", strobe, 0);
    tick(26214, 1'b1, 1'b0);
    tick(26214, 1'b0, 1'b0);
    tick(26214, 1'b1, 1'b0);
    tick(26214, 1'b0, 1'b0);
    tick(26214, 1'b0, 1'b0);
    chk("t3_min_mode", mode, 3);
    chk("t3_min_num", num, 2000);

    // Test 4: max tracking and clear
    do_reset();
    tick(0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b0);
    tick(0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) tick(0, 1'b0, 1'b0);
    chk("t4_max_mode", mode, 2);
    chk("t4_zero", num, 0);
    for (int k = 0; k < 12; k++) tick(39321, 1'b0, 1'b0);
    chk("t4_peak_3000", num, 3000);
    for (int k = 0; k < 12; k++) tick(13107, 1'b0, 1'b0);
    chk("t4_peak_held", num, 3000);
    tick(13107, 1'b0, 1'b1);
    chk("t4_clr", num, 1000);
    tick(13107, 1'b0, 1'b0);
    chk("t4_after_clr", num, 1000);

    // Test 5: simultaneous mode and clear presses in HOLD
    tick(13107, 1'b1, 1'b0);
    tick(13107, 1'b0, 1'b0);
    tick(13107, 1'b1, 1'b0);
    tick(13107, 1'b0, 1'b0);
    tick(13107, 1'b1, 1'b0);
    chk("t5_in_hold", mode, 1);
    for (int k = 0; k < 10; k++) tick(26214, 1'b0, 1'b0);
    chk("t5_hold_num", num, 1000);
    tick(26214, 1'b1, 1'b1);
    chk("t5_mode_wins", mode, 2);
    chk("t5_entry_peak", num, 2000);
    tick(26214, 1'b0, 1'b0);
    chk("t5_after", num, 2000);

    // Test 6: reset mid-ramp
    do_reset();
    for (int k = 0; k < 5; k++) tick(65535, 1'b0, 1'b0);
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick(13107, 1'b0, 1'b0);
      if (k == 7)  chk("t6_primed_e7", primed, 0);
      if (k == 8)  chk("t6_primed_e8", primed, 1);
      if (k == 10) chk("t6_num", num, 1000);
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
